// File: rtl/riscv_core_arb_pkg.sv
// Shared types and helpers for the four-way memory port arbiter.
// Round-robin pick scans upward from the pointer and wraps after index 3.
package riscv_core_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } arb_pick_t;

  // Walk offsets high to low so that the nearest requester at/after ptr wins.
  function automatic arb_pick_t rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [1:0]         ptr
  );
    arb_pick_t  p;
    logic [1:0] k;
    p = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (req[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/riscv_core_mux4x1.sv
// Plain 4:1 word mux for the shared memory port operands.
// Input word k sits at bits [k*W +: W] of the packed input.
module riscv_core_mux4x1 #(
  parameter int W = 64
) (
  input  logic [1:0]     i_sel,
  input  logic [4*W-1:0] i_data,
  output logic [W-1:0]   o_data
);

  always_comb begin
    o_data = i_data[W-1:0];
    unique case (i_sel)
      2'd0: o_data = i_data[0*W +: W];
      2'd1: o_data = i_data[1*W +: W];
      2'd2: o_data = i_data[2*W +: W];
      2'd3: o_data = i_data[3*W +: W];
      default: o_data = i_data[W-1:0];
    endcase
  end

endmodule

// File: rtl/riscv_core_arb4x1_ctrl.sv
// Sequencing arbiter for the core's single shared bus port.
// One transaction in flight: grant, bus accept, then bus response.
module riscv_core_arb4x1_ctrl
  import riscv_core_arb_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit RR_EN = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_arb_req,
  input  logic [NUM_REQ*XLEN-1:0] i_arb_addr,
  input  logic [NUM_REQ*XLEN-1:0] i_arb_wdata,
  input  logic [NUM_REQ-1:0]      i_arb_we,
  output logic [NUM_REQ-1:0]      o_arb_gnt,
  output logic [NUM_REQ-1:0]      o_arb_rvalid,
  output logic [XLEN-1:0]         o_arb_rdata,
  output logic [1:0]              o_arb_sel,
  output logic                    o_bus_valid,
  output logic [XLEN-1:0]         o_bus_addr,
  output logic [XLEN-1:0]         o_bus_wdata,
  output logic                    o_bus_we,
  input  logic                    i_bus_ready,
  input  logic                    i_bus_rvalid,
  input  logic [XLEN-1:0]         i_bus_rdata
);

  arb_state_e           state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [1:0]           ptr_nxt;
  logic [1:0]           arb_ptr;
  arb_pick_t            pick;
  logic                 done;

  assign done    = (state_q == RESP) && i_bus_rvalid;
  assign ptr_nxt = RR_EN ? sel_q + 2'd1 : 2'd0;
  // Completion re-arbitrates with the already-advanced pointer.
  assign arb_ptr = RR_EN ? (done ? ptr_nxt : ptr_q) : 2'd0;
  assign pick    = rr_pick(i_arb_req, arb_ptr);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d = REQ;
          sel_d   = pick.idx;
          gnt_d   = 4'b0001 << pick.idx;
        end
      end
      REQ: begin
        if (i_bus_ready) state_d = RESP;
      end
      RESP: begin
        if (i_bus_rvalid) begin
          ptr_d = ptr_nxt;
          if (pick.found) begin
            state_d = REQ;
            sel_d   = pick.idx;
            gnt_d   = 4'b0001 << pick.idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign o_arb_gnt    = gnt_q;
  assign o_arb_sel    = sel_q;
  assign o_bus_valid  = (state_q == REQ);
  assign o_arb_rvalid = done ? gnt_q : '0;
  assign o_arb_rdata  = i_bus_rdata;
  assign o_bus_we     = i_arb_we[sel_q];

  riscv_core_mux4x1 #(.W(XLEN)) u_addr_mux (
    .i_sel  (sel_q),
    .i_data (i_arb_addr),
    .o_data (o_bus_addr)
  );

  riscv_core_mux4x1 #(.W(XLEN)) u_wdata_mux (
    .i_sel  (sel_q),
    .i_data (i_arb_wdata),
    .o_data (o_bus_wdata)
  );

endmodule

// File: tb/tb_riscv_core_arb4x1_ctrl.sv
// Directed bench for the four-way bus arbiter.
// Covers round-robin, fixed priority, backpressure, routing, resets.
module tb_riscv_core_arb4x1_ctrl;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [4*XLEN-1:0] addr;
  logic [4*XLEN-1:0] wdata;
  logic [3:0]      we;
  logic [3:0]      gnt, rv;
  logic [XLEN-1:0] rdata;
  logic [1:0]      sel;
  logic            bus_valid, bus_we;
  logic [XLEN-1:0] bus_addr, bus_wdata;
  logic            ready, brvalid;
  logic [XLEN-1:0] brdata;

  logic [3:0]      f_req;
  logic            f_ready, f_rvalid;
  logic [3:0]      f_gnt, f_rv;
  logic [XLEN-1:0] f_rdata, f_addr, f_wdata;
  logic [1:0]      f_sel;
  logic            f_valid, f_we;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_core_arb4x1_ctrl #(.XLEN(XLEN), .RR_EN(1'b1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_arb_req    (req),
    .i_arb_addr   (addr),
    .i_arb_wdata  (wdata),
    .i_arb_we     (we),
    .o_arb_gnt    (gnt),
    .o_arb_rvalid (rv),
    .o_arb_rdata  (rdata),
    .o_arb_sel    (sel),
    .o_bus_valid  (bus_valid),
    .o_bus_addr   (bus_addr),
    .o_bus_wdata  (bus_wdata),
    .o_bus_we     (bus_we),
    .i_bus_ready  (ready),
    .i_bus_rvalid (brvalid),
    .i_bus_rdata  (brdata)
  );

  riscv_core_arb4x1_ctrl #(.XLEN(XLEN), .RR_EN(1'b0)) dut_fix (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_arb_req    (f_req),
    .i_arb_addr   (addr),
    .i_arb_wdata  (wdata),
    .i_arb_we     (we),
    .o_arb_gnt    (f_gnt),
    .o_arb_rvalid (f_rv),
    .o_arb_rdata  (f_rdata),
    .o_arb_sel    (f_sel),
    .o_bus_valid  (f_valid),
    .o_bus_addr   (f_addr),
    .o_bus_wdata  (f_wdata),
    .o_bus_we     (f_we),
    .i_bus_ready  (f_ready),
    .i_bus_rvalid (f_rvalid),
    .i_bus_rdata  (brdata)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered just after the edge that granted eg; ends just after
  // the completion edge.
  task automatic txn(input string tag, input logic [3:0] eg,
                     input logic [63:0] rd, input logic drop);
    chk({tag, "_gnt"}, 64'(gnt), 64'(eg));
    chk({tag, "_valid"}, 64'(bus_valid), 64'd1);
    if (drop) req = 4'b0000;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    chk({tag, "_resp_valid"}, 64'(bus_valid), 64'd0);
    chk({tag, "_resp_gnt"}, 64'(gnt), 64'(eg));
    brvalid = 1'b1;
    brdata  = rd;
    #1;
    chk({tag, "_rvalid"}, 64'(rv), 64'(eg));
    chk({tag, "_rdata"}, rdata, rd);
    @(posedge clk); #1;
    brvalid = 1'b0;
    #1;
    chk({tag, "_rv_off"}, 64'(rv), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'b1111;
    ready    = 1'b0;
    brvalid  = 1'b0;
    brdata   = '0;
    we       = 4'b0100;
    f_req    = 4'b0000;
    f_ready  = 1'b0;
    f_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr[k*XLEN +: XLEN]  = 64'hA000_0000_0000_0000 | 64'(k);
      wdata[k*XLEN +: XLEN] = 64'h5000_0000_0000_0000 | 64'(k);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_valid", 64'(bus_valid), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_rv", 64'(rv), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_first_gnt", 64'(gnt), 64'h1);

    txn("rr0", 4'b0001, 64'h11, 1'b0);
    txn("rr1", 4'b0010, 64'h22, 1'b0);
    txn("rr2", 4'b0100, 64'h33, 1'b0);
    txn("rr3", 4'b1000, 64'h44, 1'b0);
    txn("rr4", 4'b0001, 64'h55, 1'b1);
    chk("rr_idle_gnt", 64'(gnt), 64'd0);
    chk("rr_idle_valid", 64'(bus_valid), 64'd0);
    chk("rr_idle_sel", 64'(sel), 64'd0);

    brvalid = 1'b1;
    #1;
    chk("stray_rv", 64'(rv), 64'd0);
    @(posedge clk); #1;
    chk("stray_gnt", 64'(gnt), 64'd0);
    brvalid = 1'b0;

    req = 4'b0100;
    @(posedge clk); #1;
    chk("bp_sel", 64'(sel), 64'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(bus_valid), 64'd1);
      chk("bp_addr", bus_addr, 64'hA000_0000_0000_0002);
    end
    chk("bp_wdata", bus_wdata, 64'h5000_0000_0000_0002);
    chk("bp_we", 64'(bus_we), 64'd1);
    txn("bp", 4'b0100, 64'h0, 1'b1);

    req = 4'b0010;
    @(posedge clk); #1;
    chk("rt_gnt", 64'(gnt), 64'h2);
    chk("rt_we", 64'(bus_we), 64'd0);
    chk("rt_addr", bus_addr, 64'hA000_0000_0000_0001);
    ready   = 1'b1;
    brvalid = 1'b1;
    brdata  = 64'h1234;
    #1;
    chk("rt_acc_rv", 64'(rv), 64'd0);
    @(posedge clk); #1;
    ready   = 1'b0;
    brvalid = 1'b0;
    req     = 4'b0000;
    #1;
    chk("rt_wait_rv", 64'(rv), 64'd0);
    chk("rt_wait_gnt", 64'(gnt), 64'h2);
    chk("rt_wait_valid", 64'(bus_valid), 64'd0);
    brvalid = 1'b1;
    brdata  = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk("rt_rv", 64'(rv), 64'h2);
    chk("rt_rdata", rdata, 64'hDEAD_BEEF_0123_4567);
    @(posedge clk); #1;
    brvalid = 1'b0;
    #1;
    chk("rt_rv_1cyc", 64'(rv), 64'd0);
    chk("rt_gnt_drop", 64'(gnt), 64'd0);

    req = 4'b1000;
    @(posedge clk); #1;
    chk("ar_gnt", 64'(gnt), 64'h8);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    req   = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt_clr", 64'(gnt), 64'd0);
    chk("ar_valid_clr", 64'(bus_valid), 64'd0);
    chk("ar_sel_clr", 64'(sel), 64'd0);
    brvalid = 1'b1;
    #1;
    chk("ar_rv", 64'(rv), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_late_rv", 64'(rv), 64'd0);
    chk("ar_late_gnt", 64'(gnt), 64'd0);
    brvalid = 1'b0;
    req = 4'b0100;
    @(posedge clk); #1;
    txn("ar_next", 4'b0100, 64'h77, 1'b1);

    f_req = 4'b1010;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("fx_gnt", 64'(f_gnt), 64'h2);
      chk("fx_valid", 64'(f_valid), 64'd1);
      if (i == 2) f_req = 4'b0000;
      f_ready = 1'b1;
      @(posedge clk); #1;
      f_ready  = 1'b0;
      f_rvalid = 1'b1;
      #1;
      chk("fx_rv", 64'(f_rv), 64'h2);
      @(posedge clk); #1;
      f_rvalid = 1'b0;
    end
    chk("fx_idle_gnt", 64'(f_gnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
